// File: rtl/lut_nco_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lut_nco_scheduler
// Brief    : Phase-accumulator NCO that time-shares one cosine LUT to emit a
//            cos/sin pair per sample over a valid/ready handshake.
// Revision : 1.0
// ============================================================================
module lut_nco_scheduler #(
    parameter int ACC_BITS = 24,
    parameter int LUT_ADDR = 9,
    parameter int BITS     = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [ACC_BITS-1:0] fcw_in,
    input  logic                fcw_load,
    input  logic [LUT_ADDR-1:0] phase_off_in,
    output logic [LUT_ADDR-1:0] lut_addr,
    input  logic [BITS-1:0]     lut_data,
    output logic [BITS-1:0]     cos_out,
    output logic [BITS-1:0]     sin_out,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_COS  = 2'd1;
    localparam logic [1:0] S_SIN  = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    // A quarter turn of the table: sin(x) is read as cos(x - pi/2).
    localparam logic [LUT_ADDR-1:0] c_QUARTER = {2'b01, {(LUT_ADDR-2){1'b0}}};

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [ACC_BITS-1:0] r_acc;
    logic [ACC_BITS-1:0] r_fcw;
    logic [LUT_ADDR-1:0] r_off;
    logic [LUT_ADDR-1:0] r_lut_addr;
    logic [BITS-1:0]     r_cos;
    logic [BITS-1:0]     r_sin;

    logic [ACC_BITS-1:0] w_acc_adv;
    logic [LUT_ADDR-1:0] w_base;
    logic [LUT_ADDR-1:0] w_base_adv;
    logic [LUT_ADDR-1:0] w_start_base;
    logic [LUT_ADDR-1:0] w_cos_addr;
    logic [LUT_ADDR-1:0] w_sin_addr;
    logic                w_hs;
    logic                w_start;

    assign w_acc_adv  = r_acc + r_fcw;
    assign w_base     = r_acc[ACC_BITS-1 -: LUT_ADDR];
    assign w_base_adv = w_acc_adv[ACC_BITS-1 -: LUT_ADDR];
    assign w_hs       = (r_state == S_HOLD) && out_ready;
    assign w_start    = ((r_state == S_IDLE) || w_hs) && en;

    // A sample started from a handshake must already see the advanced phase.
    assign w_start_base = (r_state == S_HOLD) ? w_base_adv : w_base;
    assign w_cos_addr   = w_start_base + phase_off_in;
    assign w_sin_addr   = w_base + r_off - c_QUARTER;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (en) w_state_nxt = S_COS;
            S_COS:   w_state_nxt = S_SIN;
            S_SIN:   w_state_nxt = S_HOLD;
            S_HOLD:  if (out_ready) w_state_nxt = en ? S_COS : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Old fcw is used by an advance coincident with a load (non-blocking read).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_fcw <= '0;
        end else begin
            if (w_hs) begin
                r_acc <= w_acc_adv;
            end
            if (fcw_load) begin
                r_fcw <= fcw_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_off      <= '0;
            r_lut_addr <= '0;
        end else begin
            if (w_start) begin
                r_off      <= phase_off_in;
                r_lut_addr <= w_cos_addr;
            end else if (r_state == S_COS) begin
                r_lut_addr <= w_sin_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cos <= '0;
            r_sin <= '0;
        end else begin
            if (r_state == S_COS) begin
                r_cos <= lut_data;
            end
            if (r_state == S_SIN) begin
                r_sin <= lut_data;
            end
        end
    end

    assign lut_addr  = r_lut_addr;
    assign cos_out   = r_cos;
    assign sin_out   = r_sin;
    assign out_valid = (r_state == S_HOLD);

endmodule
`default_nettype wire

// File: doc/lut_nco_scheduler.md
# lut_nco_scheduler

Numerically controlled oscillator and access scheduler for the shared 512-entry, 12-bit `cosine_lut`. It keeps a phase accumulator and time-multiplexes the single combinational LUT to produce one cosine/sine pair per sample. Sine is read as cos(x − π/2). The quadrature pair feeds the BPSK modulator/demodulator mixers through a valid/ready output handshake.

## Interface
- `ACC_BITS`, 24: phase accumulator width. LUT address = `acc[ACC_BITS-1 -: LUT_ADDR]`.
- `LUT_ADDR`, 9: LUT address width (512 samples).
- `BITS`, 12: LUT sample width.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  run request; sampled in IDLE and at each output handshake.
- `fcw_in`  in  ACC_BITS  frequency control word.
- `fcw_load`  in  1  loads `fcw_in` into the FCW register.
- `phase_off_in`  in  LUT_ADDR  phase offset in LUT steps (BPSK flip = 256).
- `lut_addr`  out  LUT_ADDR  address to the external `cosine_lut` `in` port; registered.
- `lut_data`  in  BITS  `cosine_lut` `out`; combinational from `lut_addr`.
- `cos_out`  out  BITS  cosine sample, held while `out_valid`.
- `sin_out`  out  BITS  sine sample, held while `out_valid`.
- `out_valid`  out  1  sample pair available.
- `out_ready`  in  1  consumer accepts the pair.

## Operation
- Registers:
  - `acc` (ACC_BITS)
  - `fcw_reg` (ACC_BITS)
  - `off_reg` (LUT_ADDR)
  - `base` = `acc` top LUT_ADDR bits
  - state
- `fcw_load`:
  - Writes `fcw_reg` in any state.
  - The new value affects only the next accumulator advance.
  - If `fcw_load` occurs in the same cycle as an advance, the advance uses the old `fcw_reg`.
- States:
  - IDLE: `out_valid`=0; `lut_addr` holds its last value. If `en`, latch `off_reg`←`phase_off_in` and go to COS.
  - COS: `lut_addr` = `base`+`off_reg` (mod 512); capture `cos_out`←`lut_data` at end of cycle; go to SIN. During COS, `lut_addr` already presents the cos address (set at the transition), so capture is valid.
  - SIN: `lut_addr` = `base`+`off_reg`−128 (mod 512); capture `sin_out`←`lut_data`; go to HOLD.
  - HOLD: `out_valid`=1. On `out_ready`:
    - `acc`←`acc`+`fcw_reg` (mod 2^ACC_BITS).
    - If `en`: latch `off_reg`, go to COS.
    - Else: go to IDLE.
    - Without `out_ready`: stay, with outputs stable.
- `lut_addr` is registered and updated on the edge entering COS (cos address) and entering SIN (sin address). The LUT settles within the same cycle.
- Address arithmetic is unsigned LUT_ADDR-bit modular; no saturation.
- `en` deasserted mid-sample: the current COS→SIN→HOLD sequence completes and the pair is delivered. IDLE is entered only after the handshake.
- `cos_out`/`sin_out` change only at COS/SIN captures, never while `out_valid`=1.

## Timing
- Reset values: `acc`=0, `fcw_reg`=0, `off_reg`=0, `lut_addr`=0, `cos_out`=0, `sin_out`=0, `out_valid`=0, state IDLE.
- Reset mid-operation clears immediately; a pending pair is dropped.
- Latency: `en` high in IDLE at edge N → COS in cycle N+1, SIN in cycle N+2, `out_valid`=1 from cycle N+3.
- Throughput with `out_ready` held high and `en` high: one pair per 3 cycles (HOLD, COS, SIN).
- `out_valid` falls in the cycle after the handshake edge.
- Backpressure: `out_ready` low holds HOLD indefinitely; the accumulator does not advance.

## Test plan
Bench LUT model: `lut_data` = {3'b000, addr}.
- Reset: assert `rst` mid-SIN → all outputs 0 and state IDLE asynchronously, before the next edge.
- `fcw_load` with 0x008000, `off`=0, `en`=1, `out_ready`=1 → pairs (cos, sin) = (0, 384), (1, 385), (2, 386), …. `out_valid` first high 3 cycles after `en`, then every 3 cycles.
- Wrap: `fcw`=0x7F8000 (+255 steps/sample) → bases 0, 255, 510, 253 (mod 512); sin addresses = base−128 mod 512, e.g. 384, 127, 382, 125.
- BPSK flip: `phase_off_in`=256 at sample start, `fcw`=0 → cos=256, sin=128. Changing `phase_off_in` during SIN does not alter that pair.
- Backpressure: `out_ready`=0 for 10 cycles in HOLD → `out_valid`, `cos_out`, `sin_out` stable and `acc` unchanged. Release → one advance.
- `fcw_load` of 0x010000 coincident with a handshake → the next base uses the old `fcw` (+1); the following sample uses the new `fcw` (+2).
